// File: rtl/wb_regfile_if.sv
// Write-back / register-read bus between the pipeline stages and wb_regfile.
// Carries the MEM/WB commit bundle, the two ID read ports, the load
// scoreboard handshake and the debug read port.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // WB-stage commit bundle
  logic              wwreg;
  logic              wm2reg;
  logic [ADDR_W-1:0] wrd;
  logic [DATA_W-1:0] wr;
  logic [DATA_W-1:0] wdata;
  // ID-stage read ports
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  // Load scoreboard handshake
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_stall;
  // Debug read port
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  // Pipeline side: drives the bundle and indices, receives read data
  modport master (
    output wwreg, wm2reg, wrd, wr, wdata,
    output rs, rt, ld_issue, ld_rd, dbg_addr,
    input  qa, qb, ld_stall, dbg_data
  );

  // Register-file side
  modport slave (
    input  wwreg, wm2reg, wrd, wr, wdata,
    input  rs, rt, ld_issue, ld_rd, dbg_addr,
    output qa, qb, ld_stall, dbg_data
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back end of the MEM/WB pipeline register: selects the WB result,
// commits it to the general register file, serves the two ID read ports with
// an optional WB->ID bypass, and tracks outstanding loads to raise ld_stall
// on load-use hazards. r0 is hardwired to zero on every port.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic [DATA_W-1:0] wval;
  logic              byp_en;
  logic              wb_clr_rs;
  logic              wb_clr_rt;
  logic              stall_rs;
  logic              stall_rt;
  logic              ld_stall;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic [DATA_W-1:0] dbg_data;

  // Result select, hazard detection and read-port muxing
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned and infers a latch.
    wval      = bus.wm2reg ? bus.wdata : bus.wr;
    // The bypass is suppressed while reset is held so the read ports stay zero.
    byp_en    = BYPASS && reset && bus.wwreg;
    wb_clr_rs = bus.wwreg && bus.wm2reg && (bus.wrd == bus.rs);
    wb_clr_rt = bus.wwreg && bus.wm2reg && (bus.wrd == bus.rt);
    stall_rs  = (bus.rs != '0) && busy_q[bus.rs] && !(BYPASS && wb_clr_rs);
    stall_rt  = (bus.rt != '0) && busy_q[bus.rt] && !(BYPASS && wb_clr_rt);
    ld_stall  = reset && (stall_rs || stall_rt);

    qa = '0;
    if (reset && bus.rs != '0) begin
      qa = (byp_en && bus.wrd == bus.rs) ? wval : regs_q[bus.rs];
    end
    qb = '0;
    if (reset && bus.rt != '0) begin
      qb = (byp_en && bus.wrd == bus.rt) ? wval : regs_q[bus.rt];
    end
    // Debug port sees committed state only, never the in-flight WB value.
    dbg_data = reset ? regs_q[bus.dbg_addr] : '0;
  end

  assign bus.qa       = qa;
  assign bus.qb       = qb;
  assign bus.ld_stall = ld_stall;
  assign bus.dbg_data = dbg_data;

  // Next register-file contents: commit the WB result, never into r0
  always_comb begin
    regs_d = regs_q;
    if (bus.wwreg && bus.wrd != '0) begin
      regs_d[bus.wrd] = wval;
    end
  end

  // Next scoreboard: clear on load write-back, then set on issue so a newer load wins
  always_comb begin
    busy_d = busy_q;
    if (bus.wwreg && bus.wm2reg) begin
      busy_d[bus.wrd] = 1'b0;
    end
    if (bus.ld_issue && !ld_stall && bus.ld_rd != '0) begin
      busy_d[bus.ld_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers: register file and scoreboard, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this register array is reset deliberately because every entry must read 0 after reset; that rules out RAM-macro inference.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: ALU and load commits, bypass,
// r0 protection, load-use stall, set-wins scoreboard and mid-stream reset.
module tb_wb_regfile;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_wb();
    bus.wwreg  = 1'b0;
    bus.wm2reg = 1'b0;
    bus.wrd    = '0;
    bus.wr     = '0;
    bus.wdata  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_wb();
    bus.rs = '0; bus.rt = '0;
    bus.ld_issue = 1'b0; bus.ld_rd = '0;
    bus.dbg_addr = '0;

    // Reset state
    step(); step();
    bus.rs = 5'd5; bus.rt = 5'd7; bus.dbg_addr = 5'd5;
    #1;
    check("rst_qa", bus.qa, 32'h0);
    check("rst_qb", bus.qb, 32'h0);
    check("rst_stall", {31'b0, bus.ld_stall}, 32'h0);
    check("rst_dbg", bus.dbg_data, 32'h0);
    reset = 1'b1;

    // 1 ALU commit to r5; debug port must not see it before the edge
    step();
    bus.rs = 5'd0; bus.rt = 5'd0;
    bus.wwreg = 1'b1; bus.wm2reg = 1'b0; bus.wrd = 5'd5;
    bus.wr = 32'h0000_1234; bus.wdata = 32'hBAD0_BAD0;
    #1;
    check("t1_dbg_nobypass", bus.dbg_data, 32'h0);
    step();
    idle_wb();
    bus.rs = 5'd5;
    #1;
    check("t1_qa", bus.qa, 32'h0000_1234);
    check("t1_dbg", bus.dbg_data, 32'h0000_1234);

    // 2 Load commit to r7 with same-cycle bypass on qb
    bus.wwreg = 1'b1; bus.wm2reg = 1'b1; bus.wrd = 5'd7;
    bus.wdata = 32'hCAFE_F00D; bus.wr = 32'h0000_DEAD;
    bus.rt = 5'd7; bus.dbg_addr = 5'd7;
    #1;
    check("t2_qb_bypass", bus.qb, 32'hCAFE_F00D);
    check("t2_dbg_pre", bus.dbg_data, 32'h0);
    step();
    idle_wb();
    #1;
    check("t2_qb_reg", bus.qb, 32'hCAFE_F00D);
    check("t2_dbg_post", bus.dbg_data, 32'hCAFE_F00D);

    // 3 r0 protection
    bus.wwreg = 1'b1; bus.wm2reg = 1'b0; bus.wrd = 5'd0; bus.wr = 32'hFFFF_FFFF;
    bus.rs = 5'd0;
    #1;
    check("t3_qa_r0_bypass", bus.qa, 32'h0);
    step();
    idle_wb();
    bus.dbg_addr = 5'd0;
    #1;
    check("t3_qa_r0", bus.qa, 32'h0);
    check("t3_dbg_r0", bus.dbg_data, 32'h0);
    bus.rs = 5'd5;
    #1;
    check("t3_r5_intact", bus.qa, 32'h0000_1234);

    // 4 Load-use hazard on r9; a load issued while stalled is ignored
    bus.rs = 5'd0; bus.rt = 5'd0;
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
    #1;
    check("t4_no_stall_issue", {31'b0, bus.ld_stall}, 32'h0);
    step();
    bus.rs = 5'd9; bus.ld_issue = 1'b1; bus.ld_rd = 5'd11;
    #1;
    check("t4_stall_c1", {31'b0, bus.ld_stall}, 32'h1);
    step();
    bus.ld_issue = 1'b0; bus.ld_rd = '0;
    #1;
    check("t4_stall_c2", {31'b0, bus.ld_stall}, 32'h1);
    bus.wwreg = 1'b1; bus.wm2reg = 1'b1; bus.wrd = 5'd9; bus.wdata = 32'hA5A5_0009;
    #1;
    check("t4_stall_clear", {31'b0, bus.ld_stall}, 32'h0);
    check("t4_qa_bypass", bus.qa, 32'hA5A5_0009);
    step();
    idle_wb();
    #1;
    check("t4_stall_after", {31'b0, bus.ld_stall}, 32'h0);
    check("t4_qa_reg", bus.qa, 32'hA5A5_0009);
    bus.rs = 5'd0; bus.rt = 5'd11;
    #1;
    check("t4_ignored_issue", {31'b0, bus.ld_stall}, 32'h0);

    // 5 Set wins over clear on r4
    bus.rt = 5'd0;
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd4;
    step();
    bus.wwreg = 1'b1; bus.wm2reg = 1'b1; bus.wrd = 5'd4; bus.wdata = 32'h0000_0044;
    #1;
    check("t5_no_stall", {31'b0, bus.ld_stall}, 32'h0);
    step();
    idle_wb();
    bus.ld_issue = 1'b0; bus.ld_rd = '0;
    bus.rs = 5'd4;
    #1;
    check("t5_set_wins", {31'b0, bus.ld_stall}, 32'h1);
    // An ALU write to r4 is not the load write-back and keeps the stall
    bus.wwreg = 1'b1; bus.wm2reg = 1'b0; bus.wrd = 5'd4; bus.wr = 32'h0000_0077;
    #1;
    check("t5_alu_no_clear", {31'b0, bus.ld_stall}, 32'h1);
    step();
    bus.wwreg = 1'b1; bus.wm2reg = 1'b1; bus.wrd = 5'd4; bus.wdata = 32'h0000_0088;
    step();
    idle_wb();
    #1;
    check("t5_stall_done", {31'b0, bus.ld_stall}, 32'h0);
    check("t5_qa", bus.qa, 32'h0000_0088);

    // 6 Asynchronous reset mid-stream
    bus.rs = 5'd0;
    bus.wwreg = 1'b1; bus.wm2reg = 1'b0; bus.wrd = 5'd3; bus.wr = 32'h0000_0055;
    bus.ld_issue = 1'b1; bus.ld_rd = 5'd3;
    step();
    bus.ld_issue = 1'b0; bus.ld_rd = '0;
    bus.wr = 32'h0000_0077;
    bus.rs = 5'd3; bus.rt = 5'd7; bus.dbg_addr = 5'd3;
    #1;
    check("t6_pre_stall", {31'b0, bus.ld_stall}, 32'h1);
    check("t6_pre_dbg", bus.dbg_data, 32'h0000_0055);
    #1;
    reset = 1'b0;
    #1;
    check("t6_qa_rst", bus.qa, 32'h0);
    check("t6_qb_rst", bus.qb, 32'h0);
    check("t6_stall_rst", {31'b0, bus.ld_stall}, 32'h0);
    check("t6_dbg_rst", bus.dbg_data, 32'h0);
    idle_wb();
    step();
    reset = 1'b1;
    #1;
    check("t6_qa_post", bus.qa, 32'h0);
    check("t6_qb_post", bus.qb, 32'h0);
    check("t6_stall_post", {31'b0, bus.ld_stall}, 32'h0);
    bus.dbg_addr = 5'd5;
    #1;
    check("t6_dbg_r5_post", bus.dbg_data, 32'h0);
    step();
    check("t6_stall_post_edge", {31'b0, bus.ld_stall}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
